// File: rtl/cpu_fetch_queue_if.sv
// cpu_fetch_queue_if
// Bundles the fetch-side and decode-side signals of cpu_fetch_queue.
//   slave  : the queue itself (consumes i_*, drives o_*)
//   master : the surrounding pipeline (drives i_*, observes o_*)
// Signals:
//   i_tag/i_instruction/i_pc  fetch output; a changed tag marks a new instruction
//   i_flush                   discard all queued entries (redirect)
//   o_fetch_busy              queue full, fetch must hold its current tag
//   o_tag/o_instruction/o_pc  decode input; o_tag steps by one per delivered instruction
//   i_decode_busy             decode cannot take an instruction this cycle
//   o_count                   current occupancy
interface cpu_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic [7:0]             i_tag;
  logic [31:0]            i_instruction;
  logic [31:0]            i_pc;
  logic                   i_flush;
  logic                   o_fetch_busy;
  logic [7:0]             o_tag;
  logic [31:0]            o_instruction;
  logic [31:0]            o_pc;
  logic                   i_decode_busy;
  logic [$clog2(DEPTH):0] o_count;

  modport slave (
    input  i_tag, i_instruction, i_pc, i_flush, i_decode_busy,
    output o_fetch_busy, o_tag, o_instruction, o_pc, o_count
  );

  modport master (
    output i_tag, i_instruction, i_pc, i_flush, i_decode_busy,
    input  o_fetch_busy, o_tag, o_instruction, o_pc, o_count
  );
endinterface

// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue
// Decouples the fetch stage from decode with a DEPTH-entry FIFO of {instruction, pc}.
// Fetch presents a tag; any tag different from the last accepted one is a new instruction.
// Decode sees a registered output whose tag increments by one for every instruction delivered.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  asynchronous, active-high reset
//   bus      cpu_fetch_queue_if.slave (fetch inputs, decode outputs, occupancy)
// Parameters:
//   DEPTH    FIFO entries, power of two in 2..16
// Build option:
//   FETCH_QUEUE_BYPASS_EN  when defined, a new instruction arriving at an empty queue with decode
//                          idle goes straight into the output register (one-cycle latency).
//                          When undefined every instruction passes through the FIFO.
module cpu_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic               i_clock,
  input logic               i_reset,
  cpu_fetch_queue_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      last_tag_q;
  logic [7:0]      out_tag_q;
  logic [31:0]     out_instr_q;
  logic [31:0]     out_pc_q;
  logic [63:0]     mem_q [DEPTH];

  logic new_tag;
  logic full;
  logic empty;
  logic bypass;
  logic accept;
  logic pop;

  always_comb begin
    new_tag = (bus.i_tag != last_tag_q);
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // A flush forces the entry into the FIFO so the post-flush count is exactly one.
    bypass = empty && new_tag && !bus.i_decode_busy && !bus.i_flush;
`else
    bypass = 1'b0;
`endif

    // A flush empties the queue first, so a new tag is accepted even when it was full.
    accept = new_tag && !bypass && (bus.i_flush || !full);
    pop    = !bus.i_flush && !bus.i_decode_busy && !empty;

    wr_ptr_d = accept ? wr_ptr_q + PtrW'(1) : wr_ptr_q;

    if (bus.i_flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = CntW'(accept);
    end else begin
      rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q + CntW'(accept) - CntW'(pop);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_tag_q  <= '0;
      out_tag_q   <= '0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      // A rejected tag (queue full) leaves last_tag alone so it is retried next cycle.
      if (accept || bypass) begin
        last_tag_q <= bus.i_tag;
      end
      if (pop) begin
        out_tag_q   <= out_tag_q + 8'd1;
        out_instr_q <= mem_q[rd_ptr_q][63:32];
        out_pc_q    <= mem_q[rd_ptr_q][31:0];
      end else if (bypass) begin
        out_tag_q   <= out_tag_q + 8'd1;
        out_instr_q <= bus.i_instruction;
        out_pc_q    <= bus.i_pc;
      end
    end
  end

  // Storage is deliberately left unreset; count and pointers define what is valid.
  always_ff @(posedge i_clock) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {bus.i_instruction, bus.i_pc};
    end
  end

  assign bus.o_fetch_busy  = full;
  assign bus.o_count       = count_q;
  assign bus.o_tag         = out_tag_q;
  assign bus.o_instruction = out_instr_q;
  assign bus.o_pc          = out_pc_q;

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// tb_cpu_fetch_queue
// Scoreboard bench for cpu_fetch_queue at DEPTH=4. Each accepted instruction is pushed to an
// expected queue as it is driven; each delivery pops the head and all outputs are compared
// one time unit after every rising edge.
module tb_cpu_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpu_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  cpu_fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [63:0] exp_q [$];
  logic [7:0]  m_last;
  logic [7:0]  e_tag;
  logic [31:0] e_instr;
  logic [31:0] e_pc;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [7:0] t, input logic [31:0] pc);
    return {8'hE5, t, pc[15:0]};
  endfunction

  task automatic check_outputs();
    check_eq("count", 32'(bus.o_count), 32'(exp_q.size()));
    check_eq("fetch_busy", 32'(bus.o_fetch_busy), (exp_q.size() == DEPTH) ? 32'd1 : 32'd0);
    check_eq("o_tag", 32'(bus.o_tag), 32'(e_tag));
    check_eq("o_pc", bus.o_pc, e_pc);
    check_eq("o_instruction", bus.o_instruction, e_instr);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last  = '0;
    e_tag   = '0;
    e_instr = '0;
    e_pc    = '0;
  endtask

  // Drive one cycle of stimulus, update the expectation, then check after the edge.
  task automatic step(input logic [7:0] tag, input logic [31:0] pc, input logic flush,
                      input logic dbusy);
    logic        new_tag;
    logic        accept;
    logic        pop;
    logic        bypass;
    logic [63:0] e;
    bus.i_tag         = tag;
    bus.i_pc          = pc;
    bus.i_instruction = mk_instr(tag, pc);
    bus.i_flush       = flush;
    bus.i_decode_busy = dbusy;
    new_tag = (tag != m_last);
    bypass  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = (exp_q.size() == 0) && new_tag && !dbusy && !flush;
`endif
    accept = new_tag && !bypass && (flush || exp_q.size() < DEPTH);
    pop    = !flush && !dbusy && (exp_q.size() > 0);
    if (pop) begin
      e       = exp_q.pop_front();
      e_tag   = e_tag + 8'd1;
      e_instr = e[63:32];
      e_pc    = e[31:0];
    end
    if (flush) exp_q.delete();
    if (bypass) begin
      e_tag   = e_tag + 8'd1;
      e_instr = mk_instr(tag, pc);
      e_pc    = pc;
    end
    if (accept) exp_q.push_back({mk_instr(tag, pc), pc});
    if (accept || bypass) m_last = tag;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Reset pulse placed between clock edges; outputs must clear before the next edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    bus.i_tag = 8'h00;
    bus.i_pc  = 32'h0;
    bus.i_instruction = 32'h0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [7:0] cur_tag;
    logic [31:0] cur_pc;
    logic        fl;
    rst               = 1'b1;
    bus.i_tag         = '0;
    bus.i_pc          = '0;
    bus.i_instruction = '0;
    bus.i_flush       = 1'b0;
    bus.i_decode_busy = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // In-order delivery of three instructions with decode idle.
    step(8'd1, 32'h0, 1'b0, 1'b0);
    step(8'd2, 32'h4, 1'b0, 1'b0);
    step(8'd3, 32'h8, 1'b0, 1'b0);
    repeat (3) step(8'd3, 32'h8, 1'b0, 1'b0);

    // Same tag held ten cycles: only one entry.
    repeat (10) step(8'd4, 32'hC, 1'b0, 1'b1);
    repeat (2) step(8'd4, 32'hC, 1'b0, 1'b0);

    // Fill to full with decode busy; the fifth tag is held until space appears.
    for (int i = 0; i < 5; i++) step(8'(5 + i), 32'(32'h10 + 4 * i), 1'b0, 1'b1);
    repeat (2) step(8'd9, 32'h20, 1'b0, 1'b1);
    repeat (8) step(8'd9, 32'h20, 1'b0, 1'b0);

    // Flush with a new tag while three entries are queued.
    for (int i = 0; i < 3; i++) step(8'(10 + i), 32'(32'h40 + 4 * i), 1'b0, 1'b1);
    step(8'h20, 32'h100, 1'b1, 1'b1);
    repeat (3) step(8'h20, 32'h100, 1'b0, 1'b0);

    // Streaming accept+pop long enough for pointers and the output tag to wrap.
    step(8'h30, 32'h800, 1'b0, 1'b1);
    step(8'h31, 32'h804, 1'b0, 1'b1);
    for (int k = 0; k < 260; k++) step(8'(8'h32 + k), 32'(32'h1000 + 4 * k), 1'b0, 1'b0);
    repeat (3) step(8'(8'h32 + 259), 32'(32'h1000 + 4 * 259), 1'b0, 1'b0);

    // Asynchronous reset with two entries queued, then no output change on a stale tag.
    step(8'h40, 32'h2000, 1'b0, 1'b1);
    step(8'h41, 32'h2004, 1'b0, 1'b1);
    async_reset();
    repeat (3) step(8'h00, 32'h0, 1'b0, 1'b0);
    repeat (3) step(8'h42, 32'h3000, 1'b0, 1'b0);

    // Mixed random traffic.
    cur_tag = 8'h42;
    cur_pc  = 32'h3000;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        cur_tag = cur_tag + 8'($urandom_range(1, 4));
        cur_pc  = cur_pc + 32'd4;
      end
      fl = ($urandom_range(0, 15) == 0);
      step(cur_tag, cur_pc, fl, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
